// File: rtl/mpeg_decode_scheduler_if.sv
// rtl/mpeg_decode_scheduler_if.sv - demuxer timing in, decoder start out, for the decode scheduler
interface mpeg_decode_scheduler_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [31:0]   dclk;
  logic [32:0]   scr_start;
  logic          scr_start_valid;
  logic [32:0]   dts;
  logic          dts_updated;
  logic          program_end;
  logic          flush;
  logic          decoder_ready;

  logic          decode_start;
  logic [32:0]   decode_dts;
  logic          late;
  logic [CW-1:0] fifo_count;
  logic          overflow;
  logic          done;
  logic          busy;

  modport master (
    output dclk, scr_start, scr_start_valid, dts, dts_updated,
           program_end, flush, decoder_ready,
    input  decode_start, decode_dts, late, fifo_count, overflow, done, busy
  );

  modport slave (
    input  dclk, scr_start, scr_start_valid, dts, dts_updated,
           program_end, flush, decoder_ready,
    output decode_start, decode_dts, late, fifo_count, overflow, done, busy
  );
endinterface

// File: rtl/mpeg_decode_scheduler.sv
// rtl/mpeg_decode_scheduler.sv - queues demuxer DTS values and issues decode starts when dclk reaches each deadline
module mpeg_decode_scheduler #(
  parameter int DEPTH       = 4,
  parameter int LATE_THRESH = 4500
) (
  input  logic                  clk,
  input  logic                  reset,
  mpeg_decode_scheduler_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {WAIT_SYNC, ARMED, DONE} state_t;

  state_t        state_q, state_d;
  logic [32:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   base_q;
  logic          base_valid_q;
  logic          end_seen_q;
  logic          overflow_q;
  logic          decode_start_q;
  logic [32:0]   decode_dts_q;
  logic          late_q;

  logic [32:0]        head;
  logic signed [33:0] deadline, now_s, lateness;
  logic               empty, full, due, late_now;
  logic               issue, push_req, push_ok;
  logic               unused_scr_lsb;

  assign unused_scr_lsb = bus.scr_start[0];

  assign head  = mem_q[rd_ptr_q];
  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));

  // Deadline in dclk units: stream start offset plus head DTS relative to the first DTS seen.
  assign deadline = $signed({{2{bus.scr_start[32]}}, bus.scr_start[32:1]})
                  + $signed({{2{head[32]}}, head[32:1]})
                  - $signed({{2{base_q[31]}}, base_q});
  assign now_s    = $signed({2'b00, bus.dclk});
  assign lateness = now_s - deadline;
  assign due      = (now_s >= deadline);
  assign late_now = (lateness > $signed(34'(LATE_THRESH)));

  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    unique case (state_q)
      WAIT_SYNC: if (bus.scr_start_valid) state_d = ARMED;
      ARMED: begin
        if (!bus.scr_start_valid) begin
          state_d = WAIT_SYNC;
        end else if (empty) begin
          if (end_seen_q) state_d = DONE;
        end else if (due && bus.decoder_ready) begin
          issue = 1'b1;
        end
      end
      DONE:    state_d = DONE;
      default: state_d = WAIT_SYNC;
    endcase
    if (bus.flush) begin
      state_d = WAIT_SYNC;
      issue   = 1'b0;
    end
  end

  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign push_req = bus.dts_updated && (state_q != DONE) && !bus.flush;
  assign push_ok  = push_req && (!full || issue);

  always_comb begin
    count_d = count_q;
    if (push_ok && !issue) begin
      count_d = count_q + CW'(1);
    end else if (issue && !push_ok) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= bus.dts;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= WAIT_SYNC;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      base_q         <= '0;
      base_valid_q   <= 1'b0;
      end_seen_q     <= 1'b0;
      overflow_q     <= 1'b0;
      decode_start_q <= 1'b0;
      decode_dts_q   <= '0;
      late_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      decode_start_q <= issue;
      late_q         <= issue && late_now;
      if (issue) decode_dts_q <= head;
      if (bus.flush) begin
        wr_ptr_q     <= '0;
        rd_ptr_q     <= '0;
        count_q      <= '0;
        base_valid_q <= 1'b0;
        end_seen_q   <= 1'b0;
        overflow_q   <= 1'b0;
      end else begin
        count_q <= count_d;
        if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
        if (issue)   rd_ptr_q <= rd_ptr_q + AW'(1);
        if (push_ok && !base_valid_q) begin
          base_q       <= bus.dts[32:1];
          base_valid_q <= 1'b1;
        end
        if (push_req && !push_ok) overflow_q <= 1'b1;
        if (bus.program_end)      end_seen_q <= 1'b1;
      end
    end
  end

  assign bus.decode_start = decode_start_q;
  assign bus.decode_dts   = decode_dts_q;
  assign bus.late         = late_q;
  assign bus.fifo_count   = count_q;
  assign bus.overflow     = overflow_q;
  assign bus.done         = (state_q == DONE);
  assign bus.busy         = (state_q == ARMED);
endmodule

// File: tb/tb_mpeg_decode_scheduler.sv
// tb/tb_mpeg_decode_scheduler.sv - directed and randomized checks of mpeg_decode_scheduler against a queue model
module tb_mpeg_decode_scheduler;
  localparam int DEPTH       = 4;
  localparam int LATE_THRESH = 4500;
  localparam int M_WAIT  = 0;
  localparam int M_ARMED = 1;
  localparam int M_DONE  = 2;

  logic clk = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  mpeg_decode_scheduler_if #(.DEPTH(DEPTH)) bus ();

  mpeg_decode_scheduler #(.DEPTH(DEPTH), .LATE_THRESH(LATE_THRESH)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Reference model: a DTS queue plus the scheduler mode, advanced once per clock edge.
  logic [32:0] mq[$];
  int          m_mode;
  logic [31:0] m_base;
  bit          m_base_valid, m_end, m_ovf, e_start, e_late;
  logic [32:0] e_dts;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_mode = M_WAIT;
    m_base = '0;
    m_base_valid = 0;
    m_end = 0;
    m_ovf = 0;
    e_start = 0;
    e_late = 0;
    e_dts = '0;
  endtask

  task automatic model_edge();
    int     nxt;
    longint dl, now;
    e_start = 0;
    e_late  = 0;
    if (bus.flush) begin
      mq.delete();
      m_base_valid = 0;
      m_end = 0;
      m_ovf = 0;
      m_mode = M_WAIT;
      return;
    end
    nxt = m_mode;
    if (m_mode == M_WAIT && bus.scr_start_valid) nxt = M_ARMED;
    if (m_mode == M_ARMED) begin
      if (!bus.scr_start_valid) nxt = M_WAIT;
      else if (mq.size() == 0) begin
        if (m_end) nxt = M_DONE;
      end else begin
        dl  = longint'(int'(bus.scr_start[32:1])) + longint'(int'(mq[0][32:1]))
            - longint'(int'(m_base));
        now = longint'(bus.dclk);
        if (now >= dl && bus.decoder_ready) begin
          e_start = 1;
          e_late  = (now - dl) > LATE_THRESH;
          e_dts   = mq.pop_front();
        end
      end
    end
    if (bus.dts_updated && m_mode != M_DONE) begin
      if (mq.size() < DEPTH) begin
        mq.push_back(bus.dts);
        if (!m_base_valid) begin
          m_base = bus.dts[32:1];
          m_base_valid = 1;
        end
      end else begin
        m_ovf = 1;
      end
    end
    if (bus.program_end) m_end = 1;
    m_mode = nxt;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".start"}, bus.decode_start, e_start);
    check({tag, ".late"},  bus.late, e_late);
    check({tag, ".dts"},   bus.decode_dts, e_dts);
    check({tag, ".count"}, bus.fifo_count, mq.size());
    check({tag, ".ovf"},   bus.overflow, m_ovf);
    check({tag, ".done"},  bus.done, m_mode == M_DONE);
    check({tag, ".busy"},  bus.busy, m_mode == M_ARMED);
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
    bus.dts_updated = 0;
    bus.program_end = 0;
    bus.flush = 0;
  endtask

  task automatic push(input logic [32:0] v, input string tag);
    bus.dts = v;
    bus.dts_updated = 1;
    tick(tag);
  endtask

  task automatic do_reset();
    reset = 1;
    bus.dclk = '0;
    bus.scr_start = '0;
    bus.scr_start_valid = 0;
    bus.dts = '0;
    bus.dts_updated = 0;
    bus.program_end = 0;
    bus.flush = 0;
    bus.decoder_ready = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    reset = 0;
  endtask

  initial begin
    int          first, nstarts, d;
    logic [32:0] got_dts;
    logic        got_late;

    // Basic issue: deadlines at dclk 1000 and 46000
    do_reset();
    check("rst.start", bus.decode_start, 0);
    check("rst.count", bus.fifo_count, 0);
    bus.scr_start = 33'd2000;
    bus.dclk = 900;
    bus.decoder_ready = 1;
    push(33'd90000, "t1.push");
    push(33'd180000, "t1.push");
    bus.scr_start_valid = 1;
    first = -1; got_dts = '0; got_late = 1;
    for (int k = 900; k <= 1010; k++) begin
      bus.dclk = k;
      tick("t1.a");
      if (bus.decode_start && first < 0) begin
        first = k; got_dts = bus.decode_dts; got_late = bus.late;
      end
    end
    check("t1.first_dclk", first, 1000);
    check("t1.first_dts", got_dts, 90000);
    check("t1.first_late", got_late, 0);
    first = -1; got_dts = '0; got_late = 1;
    for (int k = 45990; k <= 46010; k++) begin
      bus.dclk = k;
      tick("t1.b");
      if (bus.decode_start && first < 0) begin
        first = k; got_dts = bus.decode_dts; got_late = bus.late;
      end
    end
    check("t1.second_dclk", first, 46000);
    check("t1.second_dts", got_dts, 180000);
    check("t1.second_late", got_late, 0);

    // Late flag at lateness 5000, then async reset while the pulse is high
    do_reset();
    bus.dclk = 5000;
    push(33'd0, "t2.push");
    bus.scr_start_valid = 1;
    bus.decoder_ready = 1;
    tick("t2.arm");
    check("t2.arm_busy", bus.busy, 1);
    tick("t2.iss");
    check("t2.start", bus.decode_start, 1);
    check("t2.late", bus.late, 1);
    #1 reset = 1;
    #1;
    check("ar.start", bus.decode_start, 0);
    check("ar.late", bus.late, 0);
    check("ar.dts", bus.decode_dts, 0);
    check("ar.busy", bus.busy, 0);
    check("ar.count", bus.fifo_count, 0);
    check("ar.done", bus.done, 0);
    check("ar.ovf", bus.overflow, 0);

    // Lateness exactly at threshold is not late
    do_reset();
    bus.dclk = 4500;
    push(33'd0, "t2b.push");
    bus.scr_start_valid = 1;
    bus.decoder_ready = 1;
    tick("t2b.arm");
    tick("t2b.iss");
    check("t2b.start", bus.decode_start, 1);
    check("t2b.late", bus.late, 0);

    // Full FIFO: push+pop keeps count, then a dropped push sets overflow
    do_reset();
    bus.dclk = 100000;
    for (int k = 1; k <= 4; k++) push(33'(10 * k), "t3.fill");
    check("t3.full_count", bus.fifo_count, 4);
    check("t3.full_ovf", bus.overflow, 0);
    bus.scr_start_valid = 1;
    tick("t3.arm");
    bus.decoder_ready = 1;
    push(33'd50, "t3.pp");
    check("t3.pp_start", bus.decode_start, 1);
    check("t3.pp_count", bus.fifo_count, 4);
    check("t3.pp_ovf", bus.overflow, 0);
    bus.decoder_ready = 0;
    push(33'd60, "t3.drop");
    check("t3.drop_count", bus.fifo_count, 4);
    check("t3.drop_ovf", bus.overflow, 1);
    bus.decoder_ready = 1;
    repeat (5) tick("t3.drain");

    // Back-pressure: due head held while decoder not ready
    do_reset();
    bus.dclk = 50;
    push(33'd200, "t4.push");
    bus.scr_start_valid = 1;
    nstarts = 0;
    repeat (11) begin
      tick("t4.wait");
      nstarts += int'(bus.decode_start);
    end
    check("t4.held", nstarts, 0);
    bus.decoder_ready = 1;
    tick("t4.go");
    check("t4.start", bus.decode_start, 1);
    check("t4.dts", bus.decode_dts, 200);
    tick("t4.after");
    check("t4.single", bus.decode_start, 0);

    // Drain to DONE after program_end
    do_reset();
    bus.dclk = 1000;
    push(33'd100, "t5.push");
    push(33'd300, "t5.push");
    bus.scr_start_valid = 1;
    tick("t5.arm");
    bus.program_end = 1;
    tick("t5.end");
    bus.decoder_ready = 1;
    tick("t5.i1");
    check("t5.i1_dts", bus.decode_dts, 100);
    tick("t5.i2");
    check("t5.i2_dts", bus.decode_dts, 300);
    check("t5.i2_done", bus.done, 0);
    tick("t5.d");
    check("t5.done", bus.done, 1);
    push(33'd777, "t5.ign");
    check("t5.ign_count", bus.fifo_count, 0);
    check("t5.ign_ovf", bus.overflow, 0);

    // Flush beats a same-cycle push; base re-latches from the next push
    do_reset();
    push(33'd10, "t6.push");
    push(33'd20, "t6.push");
    push(33'd30, "t6.push");
    bus.flush = 1;
    push(33'd40, "t6.fl");
    check("t6.fl_count", bus.fifo_count, 0);
    check("t6.fl_busy", bus.busy, 0);
    push(33'd5000, "t6.push2");
    bus.scr_start_valid = 1;
    bus.decoder_ready = 1;
    tick("t6.arm");
    tick("t6.iss");
    check("t6.rebase_start", bus.decode_start, 1);
    check("t6.rebase_dts", bus.decode_dts, 5000);

    // Randomized traffic against the model
    do_reset();
    bus.scr_start = 33'($urandom_range(0, 4000));
    d = 0;
    for (int i = 0; i < 600; i++) begin
      d += int'($urandom_range(0, 40));
      bus.dclk = 32'(d);
      bus.scr_start_valid = ($urandom_range(0, 19) != 0);
      bus.decoder_ready = ($urandom_range(0, 2) != 0);
      bus.dts_updated = ($urandom_range(0, 2) == 0);
      bus.dts = 33'($urandom_range(0, 30000));
      bus.program_end = ($urandom_range(0, 199) == 0);
      bus.flush = ($urandom_range(0, 149) == 0);
      tick("rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
